// File: rtl/obuft_ser_pkg.sv
// Shared state encoding and guard-counter sizing for the tristate output serializer.
// Optional parity support is selected by OBUFT_SER_PARITY_EN in the top module.
package obuft_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  localparam int GUARD_W = 4;

  // The guard counter exits on its zero flag, so it is loaded with one less than the guard length.
  function automatic logic [GUARD_W-1:0] guard_load(input int turn);
    return (turn == 0) ? '0 : GUARD_W'(turn - 1);
  endfunction

endpackage

// File: rtl/obuft_ser_guard.sv
// Loadable down-counter timing the lead and trail guard intervals around each burst.
module obuft_ser_guard
  import obuft_ser_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GUARD_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [GUARD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - GUARD_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/obuft_serializer.sv
// MSB-first parallel-to-serial stage feeding a tristate pad buffer, with driven guard cycles around bursts.
// Define OBUFT_SER_PARITY_EN to append an even-parity bit after the LSB of every word.
module obuft_serializer
  import obuft_ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   TURN_CYC = 2,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             O_I,
  output logic             O_T,
  output logic             BUSY,
  output logic             DONE
);

`ifdef OBUFT_SER_PARITY_EN
  localparam int SHIFT_LEN = WIDTH + 1;
`else
  localparam int SHIFT_LEN = WIDTH;
`endif
  localparam int                 BCNT_W     = $clog2(SHIFT_LEN + 1);
  localparam logic [BCNT_W-1:0]  BCNT_LOAD  = BCNT_W'(SHIFT_LEN);
  localparam logic [BCNT_W-1:0]  BCNT_LAST  = BCNT_W'(1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = guard_load(TURN_CYC);
  localparam bit                 HAS_GUARD  = (TURN_CYC != 0);

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [BCNT_W-1:0] bcnt;
  logic              armed;
`ifdef OBUFT_SER_PARITY_EN
  logic              par;
`endif

  logic last_bit;
  logic accept;
  logic guard_ld;
  logic guard_dec;
  logic guard_zero;

  // armed holds DIN_READY low for the first cycle after reset has been applied
  assign last_bit  = (state == ST_SHIFT) && (bcnt == BCNT_LAST);
  assign DIN_READY = armed && ((state == ST_IDLE) || last_bit);
  assign accept    = DIN_VALID && DIN_READY;
  assign guard_ld  = HAS_GUARD && (((state == ST_IDLE) && accept) || (last_bit && !accept));
  assign guard_dec = (state == ST_LEAD) || (state == ST_TRAIL);

  obuft_ser_guard u_guard (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (guard_ld),
    .load_val (GUARD_LOAD),
    .dec      (guard_dec),
    .zero     (guard_zero)
  );

  // sreg holds the bits not yet placed on O_I; O_I is loaded with the next bit one edge ahead
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      armed <= 1'b0;
      O_I   <= IDLE_VAL;
      O_T   <= 1'b1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef OBUFT_SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      DONE  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            O_T  <= 1'b0;
            BUSY <= 1'b1;
            bcnt <= BCNT_LOAD;
`ifdef OBUFT_SER_PARITY_EN
            par  <= ^DIN;
`endif
            if (HAS_GUARD) begin
              state <= ST_LEAD;
              O_I   <= IDLE_VAL;
              sreg  <= DIN;
            end else begin
              state <= ST_SHIFT;
              O_I   <= DIN[WIDTH-1];
              sreg  <= DIN << 1;
            end
          end
        end
        ST_LEAD: begin
          if (guard_zero) begin
            state <= ST_SHIFT;
            O_I   <= sreg[WIDTH-1];
            sreg  <= sreg << 1;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              O_I  <= DIN[WIDTH-1];
              sreg <= DIN << 1;
              bcnt <= BCNT_LOAD;
`ifdef OBUFT_SER_PARITY_EN
              par  <= ^DIN;
`endif
            end else if (HAS_GUARD) begin
              state <= ST_TRAIL;
              O_I   <= IDLE_VAL;
            end else begin
              state <= ST_IDLE;
              O_T   <= 1'b1;
              O_I   <= IDLE_VAL;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end else begin
            bcnt <= bcnt - BCNT_W'(1);
            sreg <= sreg << 1;
`ifdef OBUFT_SER_PARITY_EN
            O_I  <= (bcnt == BCNT_W'(2)) ? par : sreg[WIDTH-1];
`else
            O_I  <= sreg[WIDTH-1];
`endif
          end
        end
        ST_TRAIL: begin
          if (guard_zero) begin
            state <= ST_IDLE;
            O_T   <= 1'b1;
            O_I   <= IDLE_VAL;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obuft_serializer.sv
// Bench for obuft_serializer: a timeline reference model checks every cycle of the guarded instance,
// directed tables and sequences cover framing, back-to-back, zero-guard and mid-frame reset cases.
module tb_obuft_serializer;

  localparam int   W    = 8;
  localparam int   T    = 2;
  localparam logic IV   = 1'b1;
`ifdef OBUFT_SER_PARITY_EN
  localparam int   L    = W + 1;
`else
  localparam int   L    = W;
`endif
  localparam int   MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n      = 1'b0;
  logic [W-1:0] din        = '0;
  logic         din_valid  = 1'b0;
  logic         din_ready, o_i, o_t, busy, done;
  logic [W-1:0] din0       = '0;
  logic         din_valid0 = 1'b0;
  logic         din_ready0, o_i0, o_t0, busy0, done0;

  obuft_serializer #(.WIDTH(W), .TURN_CYC(T), .IDLE_VAL(IV)) dut (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .O_I(o_i), .O_T(o_t), .BUSY(busy), .DONE(done)
  );

  obuft_serializer #(.WIDTH(W), .TURN_CYC(0), .IDLE_VAL(IV)) dut0 (
    .CLK(clk), .RST_N(rst_n), .DIN(din0), .DIN_VALID(din_valid0), .DIN_READY(din_ready0),
    .O_I(o_i0), .O_T(o_t0), .BUSY(busy0), .DONE(done0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected pad waveform per cycle (cycle c = interval following rising edge c).
  logic m_t    [MAXC];
  logic m_i    [MAXC];
  logic m_busy [MAXC];
  logic m_done [MAXC];
  bit   model_on  = 1'b0;
  bit   in_rst    = 1'b0;
  int   idle_from = MAXC;
  int   last_bit  = -1;
  int   n_acc     = 0;

  function automatic bit m_ready(input int c);
    return (c >= idle_from) || (c == last_bit);
  endfunction

  function automatic void clear_from(input int e);
    for (int c = e; c < e + 64 && c < MAXC; c++) begin
      m_t[c] = 1'b1; m_i[c] = IV; m_busy[c] = 1'b0; m_done[c] = 1'b0;
    end
  endfunction

  function automatic void guard_cyc(input int c);
    m_t[c] = 1'b0; m_i[c] = IV; m_busy[c] = 1'b1;
  endfunction

  function automatic void schedule(input int e, input logic [W-1:0] w, input bit b2b);
    int ds;
    clear_from(e);
    ds = b2b ? e : e + T;
    for (int c = e; c < ds; c++) guard_cyc(c);
    for (int j = 0; j < L; j++) begin
      m_t[ds+j]    = 1'b0;
      m_busy[ds+j] = 1'b1;
      m_i[ds+j]    = (j < W) ? w[W-1-j] : ^w;
    end
    for (int c = ds + L; c < ds + L + T; c++) guard_cyc(c);
    m_done[ds+L+T] = 1'b1;
    last_bit  = ds + L - 1;
    idle_from = ds + L + T;
    n_acc++;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC - 64) begin
      if (!rst_n) begin
        clear_from(cyc);
        idle_from = MAXC;
        last_bit  = -1;
        in_rst    = 1'b1;
        model_on  = 1'b1;
      end else if (model_on) begin
        if (din_valid && m_ready(cyc - 1)) schedule(cyc, din, (cyc - 1) == last_bit);
        if (in_rst) begin
          idle_from = cyc;
          in_rst    = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && cyc < MAXC - 64) begin
      check1("o_t", o_t, m_t[cyc]);
      check1("o_i", o_i, m_i[cyc]);
      check1("busy", busy, m_busy[cyc]);
      check1("done", done, m_done[cyc]);
      check1("din_ready", din_ready, m_ready(cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && (in_rst || cyc < idle_from); n++) tick();
  endtask

  task automatic send_a(input logic [W-1:0] w, input bit keep, output int k);
    int start;
    start     = n_acc;
    din       = w;
    din_valid = 1'b1;
    k         = -1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (n_acc != start) begin
        k = cyc;
        break;
      end
    end
    if (!keep) din_valid = 1'b0;
    if (k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 100 cycles", w);
    end
  endtask

  task automatic capture(input bit sel0, output int len, output logic [31:0] pat,
                         output int mid_done, output logic end_done);
    logic t, i, d;
    len = 0; pat = '0; mid_done = 0; end_done = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      t = sel0 ? o_t0 : o_t;
      i = sel0 ? o_i0 : o_i;
      d = sel0 ? done0 : done;
      if (t) begin
        end_done = d;
        break;
      end
      pat = {pat[30:0], i};
      len++;
      if (d) mid_done++;
    end
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [31:0]  exp_pat;
    int           exp_len;
  } vec_t;

  vec_t tbl [5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          k, k2, len, md;
    logic [31:0] pat;
    logic        ed;

    for (int c = 0; c < MAXC; c++) begin
      m_t[c] = 1'b1; m_i[c] = IV; m_busy[c] = 1'b0; m_done[c] = 1'b0;
    end
`ifdef OBUFT_SER_PARITY_EN
    tbl[0] = '{8'hA5, 32'h1D2B, 13};
    tbl[1] = '{8'h00, 32'h1803, 13};
    tbl[2] = '{8'hFF, 32'h1FFB, 13};
    tbl[3] = '{8'h3C, 32'h19E3, 13};
    tbl[4] = '{8'h07, 32'h183F, 13};
`else
    tbl[0] = '{8'hA5, 32'h0E97, 12};
    tbl[1] = '{8'h00, 32'h0C03, 12};
    tbl[2] = '{8'hFF, 32'h0FFF, 12};
    tbl[3] = '{8'h3C, 32'h0CF3, 12};
    tbl[4] = '{8'h07, 32'h0C1F, 12};
`endif

    // reset held for three edges, then released
    repeat (3) tick();
    check1("rst_o_t", o_t, 1'b1);
    check1("rst_o_i", o_i, IV);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_ready", din_ready, 1'b0);
    check1("rst_o_t0", o_t0, 1'b1);
    check1("rst_ready0", din_ready0, 1'b0);
    rst_n = 1'b1;
    tick();
    check1("ready_after_rst", din_ready, 1'b1);
    check1("ready0_after_rst", din_ready0, 1'b1);

    for (int v = 0; v < 5; v++) begin
      wait_idle();
      send_a(tbl[v].din, 1'b0, k);
      capture(1'b0, len, pat, md, ed);
      check32("tbl_len", len, tbl[v].exp_len);
      check32("tbl_bits", pat, tbl[v].exp_pat);
      check32("tbl_mid_done", md, 0);
      check1("tbl_end_done", ed, 1'b1);
    end

    // back-to-back: second word waits with valid high until the final bit of the first
    wait_idle();
    send_a(8'hF0, 1'b1, k);
    k2 = -1;
    fork
      send_a(8'h0F, 1'b0, k2);
      capture(1'b0, len, pat, md, ed);
    join
    check32("b2b_accept_gap", k2 - k, T + L);
`ifdef OBUFT_SER_PARITY_EN
    check32("b2b_len", len, 22);
    check32("b2b_bits", pat, 32'h3F007B);
`else
    check32("b2b_len", len, 20);
    check32("b2b_bits", pat, 32'hFC03F);
`endif
    check32("b2b_mid_done", md, 0);
    check1("b2b_end_done", ed, 1'b1);

    // zero-guard instance: data starts immediately, no lead or trail
    check1("t0_ready", din_ready0, 1'b1);
    din0       = 8'h81;
    din_valid0 = 1'b1;
    tick();
    din_valid0 = 1'b0;
    capture(1'b1, len, pat, md, ed);
`ifdef OBUFT_SER_PARITY_EN
    check32("t0_len", len, 9);
    check32("t0_bits", pat, 32'h102);
`else
    check32("t0_len", len, 8);
    check32("t0_bits", pat, 32'h81);
`endif
    check32("t0_mid_done", md, 0);
    check1("t0_end_done", ed, 1'b1);
    for (int n = 0; n < 4; n++) begin
      din0 = W'($urandom);
      tick();
    end
    check1("t0_nohs_o_t", o_t0, 1'b1);
    check1("t0_nohs_busy", busy0, 1'b0);

    // reset during the fourth data bit releases the pad at once without DONE
    wait_idle();
    send_a(8'h3C, 1'b0, k);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check1("midrst_o_t", o_t, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    rst_n = 1'b1;
    wait_idle();
    send_a(tbl[0].din, 1'b0, k);
    capture(1'b0, len, pat, md, ed);
    check32("post_rst_len", len, tbl[0].exp_len);
    check32("post_rst_bits", pat, tbl[0].exp_pat);

    // randomized traffic including occasional resets; every cycle checked by the model
    for (int n = 0; n < 500; n++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
